// File: rtl/volt_to_dac_pkg.sv
// Shared definitions for the millivolt-setpoint to DAC-code converter.
// Holds the DAC format, the BCD/accumulator sizes, the fixed-point scale
// factor, the ASCII sign codes, the FSM state encoding and the result record
// produced by the output stage.
package volt_to_dac_pkg;

    localparam int DAC_W      = 12;     // DAC code width, two's complement
    localparam int FS_MV      = 5000;   // full-scale magnitude in mV -> code 2^(DAC_W-1)
    localparam int SCALE_K    = 26844;  // round(2^16 * 2048 / 5000)
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int ACC_W      = 17;     // holds 99999

    localparam logic [7:0] ASCII_PLUS  = 8'd43;
    localparam logic [7:0] ASCII_MINUS = 8'd45;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_MUL  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DAC_W-1:0] code;
        logic             sat;
        logic             err;
    } dac_res_t;

endpackage

// File: rtl/volt_to_dac_bcd2bin.sv
// Serial 5-digit BCD to 17-bit binary converter (x10-accumulate, MSD first).
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (control state only)
//   start_i  load bcd_i and clear the accumulator (ignored while running)
//   bcd_i    5 BCD digits, [19:16] = ten-thousands
//   done_o   high in the cycle the last digit is consumed; bin_o/bad_o are
//            valid from the following cycle and hold until the next start
//   bin_o    binary value
//   bad_o    at least one digit was > 9
module volt_to_dac_bcd2bin
    import volt_to_dac_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [BCD_W-1:0] bcd_i,
    output logic             done_o,
    output logic [ACC_W-1:0] bin_o,
    output logic             bad_o
);

    logic             run_q, run_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0] sh_q, sh_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             bad_q, bad_d;
    logic [3:0]       digit;

    // Digits are shifted out of the top nibble, so the MSD goes first.
    assign digit = sh_q[BCD_W-1 -: 4];

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        sh_d  = sh_q;
        acc_d = acc_q;
        bad_d = bad_q;
        if (start_i && !run_q) begin
            run_d = 1'b1;
            cnt_d = 3'd0;
            sh_d  = bcd_i;
            acc_d = '0;
            bad_d = 1'b0;
        end else if (run_q) begin
            // A bad digit is flagged but still folded in; the result is discarded anyway.
            acc_d = acc_q * ACC_W'(10) + ACC_W'(digit);
            bad_d = bad_q | (digit > 4'd9);
            sh_d  = {sh_q[BCD_W-5:0], 4'd0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(BCD_DIGITS - 1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q <= 1'b0;
            cnt_q <= 3'd0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        sh_q  <= sh_d;
        acc_q <= acc_d;
        bad_q <= bad_d;
    end

    assign done_o = run_q && (cnt_q == 3'(BCD_DIGITS - 1));
    assign bin_o  = acc_q;
    assign bad_o  = bad_q;

endmodule

// File: rtl/volt_to_dac.sv
// Signed BCD millivolt setpoint -> 12-bit two's-complement DAC code
// (1 LSB = 5 V / 2048), with start/busy/done handshake.
// Ports:
//   da_clk    clock, rising edge
//   rst       synchronous active-high reset; aborts a conversion
//   start     one-cycle request, accepted only when idle
//   vol_dec   magnitude, 5 BCD digits
//   vol_sig   ASCII sign, '+' (43) or '-' (45)
//   busy      conversion in progress
//   done      one-cycle pulse; dac_code/sat/err valid from this cycle
//   dac_code  DAC code, held between conversions
//   sat       last result was clamped to full scale
//   err       last request had a bad digit or sign; dac_code was kept
module volt_to_dac
    import volt_to_dac_pkg::*;
(
    input  logic             da_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BCD_W-1:0] vol_dec,
    input  logic [7:0]       vol_sig,
    output logic             busy,
    output logic             done,
    output logic [DAC_W-1:0] dac_code,
    output logic             sat,
    output logic             err
);

    localparam logic [ACC_W-1:0] POS_MAX = ACC_W'((1 << (DAC_W - 1)) - 1);
    localparam logic [ACC_W-1:0] NEG_MAX = ACC_W'(1 << (DAC_W - 1));

    state_t           state_q, state_d;
    logic [7:0]       sign_q, sign_d;
    logic [ACC_W-1:0] mag_q, mag_d;
    logic [DAC_W-1:0] code_q, code_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             accept;
    logic             bcd_done;
    logic [ACC_W-1:0] bcd_bin;
    logic             bcd_bad;
    dac_res_t         res;

    // mV -> code magnitude, rounded half-up: (mv*K + 2^15) >> 16.
    function automatic logic [ACC_W-1:0] scale_round(input logic [ACC_W-1:0] mv);
        logic [32:0] prod;
        prod = 33'(mv) * 33'(SCALE_K) + 33'd32768;
        return ACC_W'(prod >> 16);
    endfunction

    // Error check, sign application and clamping, in priority order.
    function automatic dac_res_t saturate(input logic [ACC_W-1:0] mag,
                                          input logic [7:0]       sgn,
                                          input logic             bad,
                                          input logic [DAC_W-1:0] prev);
        dac_res_t                r;
        logic signed [DAC_W-1:0] neg;
        neg    = -signed'(mag[DAC_W-1:0]);
        r.code = prev;
        r.sat  = 1'b0;
        r.err  = 1'b0;
        if (bad || (sgn != ASCII_PLUS && sgn != ASCII_MINUS)) begin
            r.err = 1'b1;
        end else if (sgn == ASCII_PLUS && mag > POS_MAX) begin
            r.code = {1'b0, {(DAC_W-1){1'b1}}};
            r.sat  = 1'b1;
        end else if (sgn == ASCII_MINUS && mag > NEG_MAX) begin
            r.code = {1'b1, {(DAC_W-1){1'b0}}};
            r.sat  = 1'b1;
        end else if (sgn == ASCII_MINUS) begin
            // mag == 2048 wraps to 12'h800, which is exactly -2048.
            r.code = neg;
        end else begin
            r.code = mag[DAC_W-1:0];
        end
        return r;
    endfunction

    assign accept = start && (state_q == ST_IDLE);

    volt_to_dac_bcd2bin u_bcd2bin (
        .clk_i   (da_clk),
        .rst_i   (rst),
        .start_i (accept),
        .bcd_i   (vol_dec),
        .done_o  (bcd_done),
        .bin_o   (bcd_bin),
        .bad_o   (bcd_bad)
    );

    assign res = saturate(mag_q, sign_q, bcd_bad, code_q);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        code_d  = code_q;
        sat_d   = sat_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d  = vol_sig;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (bcd_done) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                mag_d   = scale_round(bcd_bin);
                state_d = ST_OUT;
            end
            ST_OUT: begin
                code_d  = res.code;
                sat_d   = res.sat;
                err_d   = res.err;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge da_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge da_clk) begin
        sign_q <= sign_d;
        mag_q  <= mag_d;
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign dac_code = code_q;
    assign sat      = sat_q;
    assign err      = err_q;

endmodule
